// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - two-requester round-robin front end for a shared divider
//
// Purpose: arbitrates two requesters onto one divider. Serves one division
// at a time and returns the result on a shared response bus.
// Optional feature: define DIV_ARB_TIMEOUT_EN to add a WAIT timeout counter
// and the ABORT state.
//
// Ports:
//   clk, sclr             clock, asynchronous active-high reset
//   req0/1, a0/b0, a1/b1  requests and operands (held until ackN)
//   ack0/1                one-cycle pulse, operands of requester N captured
//   rvalid0/1             one-cycle pulse, shared result valid for requester N
//   q_out, dvz_out,
//   ovf_out, err_out      shared result bus, qualified by rvalidN
//   busy                  high whenever the FSM is not IDLE
//   div_a, div_b,
//   div_start, div_sclr   divider operands, start pulse and synchronous clear
//   div_q, div_dvz,
//   div_ovf, div_busy,
//   div_valid             divider results
module div_arbiter #(
   parameter int WIDTH   = 10,
   parameter int TIMEOUT = 32
) (
   input  logic             clk,
   input  logic             sclr,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack0,
   output logic             ack1,
   output logic             rvalid0,
   output logic             rvalid1,
   output logic [WIDTH-1:0] q_out,
   output logic             dvz_out,
   output logic             ovf_out,
   output logic             err_out,
   output logic             busy,
   output logic [WIDTH-1:0] div_a,
   output logic [WIDTH-1:0] div_b,
   output logic             div_start,
   output logic             div_sclr,
   input  logic [WIDTH-1:0] div_q,
   input  logic             div_dvz,
   input  logic             div_ovf,
   input  logic             div_busy,
   input  logic             div_valid
);

`ifdef DIV_ARB_TIMEOUT_EN
   typedef enum logic [2:0] {IDLE, START, WAIT, RESP, ABORT} state_t;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] wait_cnt_q;
   logic             err_q;
`else
   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
   localparam int unused_timeout = TIMEOUT;
`endif

   state_t           state_q;
   logic             sel_q;        // requester being served
   logic             prio_q;       // requester that wins a tie next
   logic             ack0_q, ack1_q, rvalid0_q, rvalid1_q;
   logic             div_start_q, div_sclr_q;
   logic [WIDTH-1:0] div_a_q, div_b_q, q_q;
   logic             dvz_q, ovf_q;
   logic             grant_d;

   // The divider's own busy flag adds nothing: the FSM already tracks it.
   logic unused_div_busy;
   assign unused_div_busy = div_busy;

   // Round-robin: a tie goes to the priority pointer, otherwise the sole requester.
   assign grant_d = (req0 && req1) ? prio_q : req1;

   always_ff @(posedge clk or posedge sclr) begin
      if (sclr) begin
         state_q     <= IDLE;
         sel_q       <= 1'b0;
         prio_q      <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         div_start_q <= 1'b0;
         // Stays set through the first edge after release so the divider clears.
         div_sclr_q  <= 1'b1;
         div_a_q     <= '0;
         div_b_q     <= '0;
         q_q         <= '0;
         dvz_q       <= 1'b0;
         ovf_q       <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         div_start_q <= 1'b0;
         div_sclr_q  <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
         err_q       <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  sel_q       <= grant_d;
                  div_a_q     <= grant_d ? a1 : a0;
                  div_b_q     <= grant_d ? b1 : b0;
                  ack0_q      <= ~grant_d;
                  ack1_q      <= grant_d;
                  div_start_q <= 1'b1;
                  state_q     <= START;
               end
            end
            START: begin
`ifdef DIV_ARB_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
               state_q <= WAIT;
            end
            WAIT: begin
               if (div_valid) begin
                  q_q       <= div_q;
                  dvz_q     <= div_dvz;
                  ovf_q     <= div_ovf;
                  rvalid0_q <= ~sel_q;
                  rvalid1_q <= sel_q;
                  state_q   <= RESP;
               end
`ifdef DIV_ARB_TIMEOUT_EN
               else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  // Divider is hung: clear it and report an error response.
                  q_q        <= '0;
                  dvz_q      <= 1'b0;
                  ovf_q      <= 1'b0;
                  err_q      <= 1'b1;
                  div_sclr_q <= 1'b1;
                  rvalid0_q  <= ~sel_q;
                  rvalid1_q  <= sel_q;
                  state_q    <= ABORT;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
`endif
            end
            RESP: begin
               prio_q  <= ~sel_q;
               state_q <= IDLE;
            end
`ifdef DIV_ARB_TIMEOUT_EN
            ABORT: begin
               prio_q  <= ~sel_q;
               state_q <= IDLE;
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign rvalid0   = rvalid0_q;
   assign rvalid1   = rvalid1_q;
   assign q_out     = q_q;
   assign dvz_out   = dvz_q;
   assign ovf_out   = ovf_q;
   assign busy      = (state_q != IDLE);
   assign div_a     = div_a_q;
   assign div_b     = div_b_q;
   assign div_start = div_start_q;
   assign div_sclr  = div_sclr_q;
`ifdef DIV_ARB_TIMEOUT_EN
   assign err_out   = err_q;
`else
   assign err_out   = 1'b0;
`endif

endmodule
